ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit directly downstream of the program counter.
//  - Issues the current PC to instruction memory over a req/gnt/rvalid handshake.
//  - Buffers returned instructions, tagged with their addresses, in an in-order prefetch FIFO.
//  - Presents instructions to decode through a valid/ready handshake.
//  - Drives pc_stopFlag_o so the PC advances only when its address has been granted.
//  - Discards in-flight fetches on a taken jump (flush).
// PARAMETERS
//  FIFO_DEPTH  2             prefetch entries; power of 2, >=2; also max outstanding requests
//  ADDR_W      32            instruction address width
//  DATA_W      32            instruction width
//  NOP_INST    32'h00000013  value on inst_o when not valid (addi x0,x0,0)
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       reset, asynchronous, active-low
//  pc_i           in   ADDR_W  current PC from PC stage
//  flush_i        in   1       taken jump/branch this cycle (PCSel==ALU); PC loads target next edge
//  pc_stopFlag_o  out  1       1 = PC holds; 0 = PC advances at next edge
//  imem_req_o     out  1       fetch request
//  imem_addr_o    out  ADDR_W  fetch address, word aligned
//  imem_gnt_i     in   1       request accepted this cycle
//  imem_rvalid_i  in   1       read data valid; responses return in order, >=1 cycle after gnt
//  imem_rdata_i   in   DATA_W  read data
//  inst_valid_o   out  1       inst_o/inst_addr_o valid
//  inst_o         out  DATA_W  instruction to decode
//  inst_addr_o    out  ADDR_W  address of inst_o
//  inst_fault_o   out  1       misaligned-fetch fault flag (see CONFIGURATION)
//  id_ready_i     in   1       decode accepts; pop when inst_valid_o & id_ready_i
// BEHAVIOUR
//  Reset (rst_i low, async):
//  - FIFO empty; outstanding count = 0; discard count = 0.
//  - inst_valid_o = 0, inst_o = NOP_INST, inst_addr_o = 0, inst_fault_o = 0, imem_req_o = 0.
//  - pc_stopFlag_o = 1.
//  Credits: credit = fifo_count + outstanding - discard.
//  - imem_req_o = !flush_i & (credit < FIFO_DEPTH), combinational.
//  - Nothing requests beyond buffer space, so the FIFO never overflows.
//  Addressing and PC control:
//  - imem_addr_o = {pc_i[ADDR_W-1:2], 2'b00}.
//  - pc_stopFlag_o = ~(imem_req_o & imem_gnt_i), combinational.
//  - On grant, push pc_i into the address queue and increment outstanding.
//  Response:
//  - On imem_rvalid_i with discard > 0: decrement discard and outstanding; the data is dropped.
//  - Otherwise push {addr_queue head, imem_rdata_i} into the FIFO.
//  - Data is registered; earliest inst_valid_o is the cycle after rvalid. Fetch latency >= 2 cycles.
//  Output:
//  - FIFO head drives inst_o / inst_addr_o.
//  - Empty FIFO: inst_valid_o = 0, inst_o = NOP_INST.
//  - Simultaneous push and pop are legal at any occupancy, including full.
//  Flush (flush_i = 1) at the edge:
//  - FIFO and address queue are cleared.
//  - discard <= outstanding - (rvalid this cycle ? 1 : 0).
//  - No request is issued in the flush cycle; pc_stopFlag_o = 0 there so the PC loads its target.
//  - The first request for the target issues the following cycle.
//  - A pop in the flush cycle completes; the flush still clears the remaining entries.
//  Boundaries:
//  - Wrap: read/write pointers wrap modulo FIFO_DEPTH.
//  - rvalid with outstanding = 0 is a protocol error and is ignored.
//  - Async reset mid-transaction drops all state. The memory side must also reset.
// CONFIGURATION
//  Macro IFU_MISALIGN_CHECK_EN.
//  - Defined, pc_i[1:0] != 0 (when not flushing): no request is issued.
//    - Once credit < FIFO_DEPTH, one fault entry is pushed: inst_fault_o = 1, inst_o = NOP_INST, inst_addr_o = pc_i.
//    - pc_stopFlag_o = 1 until flush_i.
//  - Undefined: pc_i[1:0] ignored; inst_fault_o tied 0.
// TESTING
//  1. Reset, gnt=1, rvalid 1 cycle after gnt, id_ready=1, pc 0x0,0x4,0x8 -> inst_valid from cycle 3, addrs 0x0/0x4/0x8 back to back.
//  2. id_ready=0, DEPTH=2 -> two grants, then imem_req_o=0 and pc_stopFlag_o=1; id_ready=1 -> pops 0x0 then 0x4, requests resume.
//  3. gnt held 0 for 3 cycles -> pc_stopFlag_o=1 all three cycles, pc_i stable, no FIFO push.
//  4. Two outstanding fetches, flush_i=1, pc_i jumps to 0x100 -> both stale responses dropped, first inst_valid has inst_addr_o=0x100.
//  5. Full FIFO with pop and rvalid in the same cycle -> count stays 2, order preserved, no loss or duplicate.
//  6. IFU_MISALIGN_CHECK_EN, pc_i=0x102 -> no imem_req_o, inst_fault_o=1 with inst_addr_o=0x102, stall until flush to 0x200 resumes fetch.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited imem requests, in-order prefetch FIFO, flush discard.
// Optional misaligned-PC fault entry enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] NOP_INST   = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              pc_stopFlag_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_fault_o,
  input  logic              id_ready_i
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Stale fetches can pile up across back-to-back flushes, so these counters get headroom.
  localparam int unsigned OUT_W = CNT_W + 4;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [ADDR_W-1:0] aq_mem    [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W-1:0] aq_rd_reg, aq_wr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [OUT_W-1:0] outstanding_reg, discard_reg;

  logic [OUT_W-1:0]  live, credit;
  logic              grant, rsp_ok, rsp_drop, rsp_push;
  logic              push, pop, misaligned, fault_push;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] push_addr;

  assign live   = outstanding_reg - discard_reg;
  assign credit = OUT_W'(count_reg) + live;

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_mem [FIFO_DEPTH];
  logic fault_sent_reg;

  assign misaligned = |pc_i[1:0];
  // Wait for live fetches to drain so the fault entry lands behind them in order.
  assign fault_push = misaligned & ~flush_i & ~fault_sent_reg & (live == '0)
                    & (credit < OUT_W'(FIFO_DEPTH));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      fault_sent_reg <= 1'b0;
    else if (flush_i)
      fault_sent_reg <= 1'b0;
    else if (fault_push)
      fault_sent_reg <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i)
      fault_mem[wr_ptr_reg] <= fault_push;
  end

  assign inst_fault_o = inst_valid_o & fault_mem[rd_ptr_reg];
`else
  assign misaligned   = 1'b0;
  assign fault_push   = 1'b0;
  assign inst_fault_o = 1'b0;
`endif

  assign imem_req_o    = rst_i & ~flush_i & ~misaligned & (credit < OUT_W'(FIFO_DEPTH));
  assign imem_addr_o   = {pc_i[ADDR_W-1:2], 2'b00};
  assign grant         = imem_req_o & imem_gnt_i;
  assign pc_stopFlag_o = ~rst_i | (~flush_i & ~grant);

  assign rsp_ok    = imem_rvalid_i & (outstanding_reg != '0);
  assign rsp_drop  = rsp_ok & (discard_reg != '0);
  assign rsp_push  = rsp_ok & ~rsp_drop;
  assign push      = rsp_push | fault_push;
  assign pop       = inst_valid_o & id_ready_i;
  assign push_data = fault_push ? NOP_INST : imem_rdata_i;
  assign push_addr = fault_push ? pc_i : aq_mem[aq_rd_reg];

  assign inst_valid_o = (count_reg != '0);
  assign inst_o       = inst_valid_o ? fifo_data[rd_ptr_reg] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? fifo_addr[rd_ptr_reg] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      aq_rd_reg       <= '0;
      aq_wr_reg       <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else if (flush_i) begin
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      aq_rd_reg       <= '0;
      aq_wr_reg       <= '0;
      count_reg       <= '0;
      // Everything still in flight after this cycle belongs to the old path.
      outstanding_reg <= outstanding_reg - OUT_W'(rsp_ok);
      discard_reg     <= outstanding_reg - OUT_W'(rsp_ok);
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (grant)
        aq_wr_reg <= aq_wr_reg + PTR_W'(1);
      if (rsp_push)
        aq_rd_reg <= aq_rd_reg + PTR_W'(1);
      outstanding_reg <= outstanding_reg + OUT_W'(grant) - OUT_W'(rsp_ok);
      if (rsp_drop)
        discard_reg <= discard_reg - OUT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      fifo_data[wr_ptr_reg] <= push_data;
      fifo_addr[wr_ptr_reg] <= push_addr;
    end
    if (grant)
      aq_mem[aq_wr_reg] <= pc_i;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch: PC and memory environment plus a queue of expected live fetches.
// Defining IFU_MISALIGN_CHECK_EN switches the misaligned-PC scenario to the fault-entry variant.
`timescale 1ns/1ps
module tb_ifu_fetch;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk_i         = 1'b0;
  logic        rst_i         = 1'b1;
  logic [31:0] pc_i          = '0;
  logic        flush_i       = 1'b0;
  logic        imem_gnt_i    = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = '0;
  logic        id_ready_i    = 1'b0;
  logic        pc_stopFlag_o, imem_req_o, inst_valid_o, inst_fault_o;
  logic [31:0] imem_addr_o, inst_o, inst_addr_o;

  always #5 clk_i = ~clk_i;

  ifu_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .NOP_INST(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .flush_i(flush_i),
    .pc_stopFlag_o(pc_stopFlag_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_fault_o(inst_fault_o), .id_ready_i(id_ready_i)
  );

  typedef struct { logic [31:0] addr; int due; } rsp_t;

  int          vectors = 0, miscompares = 0;
  int          cyc = 0, last_due = 0;
  logic [31:0] pc = '0;
  logic [31:0] pend[$];
  rsp_t        memq[$];
  int          gnt_pct = 100, dmin = 1, dmax = 1, flush_pct = 0;
  bit          rdy_rand = 1'b0, rdy_fixed = 1'b1;
  bit          flush_now = 1'b0;
  logic [31:0] flush_tgt = '0;
  bit          obs_valid, obs_req, obs_stop;
  int          pops = 0, fault_pops = 0;
  bit          first_pop_seen = 1'b0;
  logic [31:0] first_pop_addr = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  // One clock cycle: drive at the falling edge, check 1ns later, update models, advance.
  task automatic cycle();
    bit          gnt, rv, mis, exp_req, exp_stop, pop;
    logic [31:0] rd, e, pc_now;
    rsp_t        r;
    gnt = ($urandom_range(99, 0) < gnt_pct);
    if (flush_pct > 0 && $urandom_range(99, 0) < flush_pct) begin
      flush_now = 1'b1;
      flush_tgt = $urandom & 32'h0000FFFC;
    end
    rv = 1'b0;
    rd = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rv = 1'b1;
      rd = memf(memq[0].addr);
    end
    pc_now        = pc;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    pc_i          = pc_now;
    flush_i       = flush_now;
    id_ready_i    = rdy_rand ? ($urandom_range(3, 0) != 0) : rdy_fixed;
    #1;
`ifdef IFU_MISALIGN_CHECK_EN
    mis = (pc_now[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    exp_req  = !flush_now && !mis && (pend.size() < DEPTH);
    exp_stop = flush_now ? 1'b0 : !(exp_req && gnt);
    obs_valid = (inst_valid_o === 1'b1);
    obs_req   = (imem_req_o === 1'b1);
    obs_stop  = (pc_stopFlag_o === 1'b1);

    vectors++;
    if (imem_req_o !== exp_req) begin
      miscompares++;
      $display("FAIL req cyc=%0d got=%b want=%b", cyc, imem_req_o, exp_req);
    end
    vectors++;
    if (pc_stopFlag_o !== exp_stop) begin
      miscompares++;
      $display("FAIL stop cyc=%0d got=%b want=%b", cyc, pc_stopFlag_o, exp_stop);
    end
    if (exp_req) begin
      vectors++;
      if (imem_addr_o !== {pc_now[31:2], 2'b00}) begin
        miscompares++;
        $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr_o, {pc_now[31:2], 2'b00});
      end
    end

    pop = (inst_valid_o === 1'b1) && (id_ready_i === 1'b1);
    if (pop) begin
      vectors++;
      if (pend.size() == 0) begin
        if (mis) begin
          fault_pops++;
          if (inst_fault_o !== 1'b1 || inst_addr_o !== pc_now || inst_o !== NOP) begin
            miscompares++;
            $display("FAIL fault_entry cyc=%0d got fault=%b addr=%h inst=%h want fault=1 addr=%h inst=%h",
                     cyc, inst_fault_o, inst_addr_o, inst_o, pc_now, NOP);
          end
        end else begin
          miscompares++;
          $display("FAIL spurious_pop cyc=%0d got addr=%h inst=%h want no valid entry", cyc, inst_addr_o, inst_o);
        end
      end else begin
        e = pend.pop_front();
        if (inst_addr_o !== e || inst_o !== memf({e[31:2], 2'b00}) || inst_fault_o !== 1'b0) begin
          miscompares++;
          $display("FAIL pop_entry cyc=%0d got addr=%h inst=%h fault=%b want addr=%h inst=%h fault=0",
                   cyc, inst_addr_o, inst_o, inst_fault_o, e, memf({e[31:2], 2'b00}));
        end
      end
      pops++;
      if (!first_pop_seen) begin
        first_pop_seen = 1'b1;
        first_pop_addr = inst_addr_o;
      end
    end else if (inst_valid_o !== 1'b1) begin
      vectors++;
      if (inst_o !== NOP) begin
        miscompares++;
        $display("FAIL idle_inst cyc=%0d got=%h want=%h", cyc, inst_o, NOP);
      end
    end

    if (rv)
      r = memq.pop_front();
    if (imem_req_o === 1'b1 && gnt) begin
      r.addr = imem_addr_o;
      r.due  = cyc + $urandom_range(dmax, dmin);
      if (r.due <= last_due)
        r.due = last_due + 1;
      last_due = r.due;
      memq.push_back(r);
    end

    if (flush_now) begin
      pend.delete();
      pc = flush_tgt;
    end else begin
      if (exp_req && gnt)
        pend.push_back(pc_now);
      if (pc_stopFlag_o === 1'b0)
        pc = pc + 32'd4;
    end
    flush_now = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic apply_reset();
    #2;
    rst_i         = 1'b0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    id_ready_i    = 1'b0;
    flush_now     = 1'b0;
    #1;
    vectors++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out got valid=%b inst=%h addr=%h want valid=0 inst=%h addr=0",
               inst_valid_o, inst_o, inst_addr_o, NOP);
    end
    vectors++;
    if (imem_req_o !== 1'b0 || pc_stopFlag_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ctrl got req=%b stop=%b want req=0 stop=1", imem_req_o, pc_stopFlag_o);
    end
    vectors++;
    if (inst_fault_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fault got=%b want=0", inst_fault_o);
    end
    pend.delete();
    memq.delete();
    last_due       = 0;
    pc             = '0;
    first_pop_seen = 1'b0;
    rdy_rand       = 1'b0;
    rdy_fixed      = 1'b1;
    gnt_pct        = 100;
    dmin           = 1;
    dmax           = 1;
    flush_pct      = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc++;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_basic();
    int first_valid;
    first_valid = -1;
    apply_reset();
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_valid && first_valid < 0)
        first_valid = k;
    end
    vectors++;
    if (first_valid != 2) begin
      miscompares++;
      $display("FAIL first_valid got=%0d want=2", first_valid);
    end
    vectors++;
    if (!first_pop_seen || first_pop_addr !== 32'h0 || pops < 3) begin
      miscompares++;
      $display("FAIL basic_stream got first=%h pops=%0d want first=0 pops>=3", first_pop_addr, pops);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rdy_fixed = 1'b0;
    for (int k = 0; k < 6; k++)
      cycle();
    vectors++;
    if (obs_req !== 1'b0 || obs_stop !== 1'b1 || obs_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_full got req=%b stop=%b valid=%b want req=0 stop=1 valid=1", obs_req, obs_stop, obs_valid);
    end
    pops = 0;
    rdy_fixed = 1'b1;
    for (int k = 0; k < 6; k++)
      cycle();
    vectors++;
    if (!first_pop_seen || first_pop_addr !== 32'h0 || pops < 2) begin
      miscompares++;
      $display("FAIL resume_order got first=%h pops=%0d want first=0 pops>=2", first_pop_addr, pops);
    end
  endtask

  task automatic test_gnt_stall();
    apply_reset();
    gnt_pct = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      vectors++;
      if (obs_stop !== 1'b1 || pc !== 32'h0 || obs_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL gnt_stall k=%0d got stop=%b pc=%h valid=%b want stop=1 pc=0 valid=0", k, obs_stop, pc, obs_valid);
      end
    end
    gnt_pct = 100;
    pops = 0;
    for (int k = 0; k < 8; k++)
      cycle();
    vectors++;
    if (pops == 0) begin
      miscompares++;
      $display("FAIL gnt_resume got pops=%0d want >0", pops);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    dmin = 6;
    dmax = 6;
    cycle();
    cycle();
    flush_now = 1'b1;
    flush_tgt = 32'h100;
    first_pop_seen = 1'b0;
    dmin = 1;
    dmax = 1;
    cycle();
    for (int k = 0; k < 30 && !first_pop_seen; k++)
      cycle();
    vectors++;
    if (!first_pop_seen || first_pop_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL flush_target got seen=%b addr=%h want seen=1 addr=00000100", first_pop_seen, first_pop_addr);
    end
  endtask

  task automatic test_full_pop();
    apply_reset();
    rdy_fixed = 1'b0;
    for (int k = 0; k < 5; k++)
      cycle();
    vectors++;
    if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fill got valid=%b req=%b want valid=1 req=0", obs_valid, obs_req);
    end
    rdy_fixed = 1'b1;
    pops = 0;
    for (int k = 0; k < 12; k++)
      cycle();
    vectors++;
    if (pops < 6) begin
      miscompares++;
      $display("FAIL stream_pops got=%0d want>=6", pops);
    end
  endtask

  task automatic test_random();
    apply_reset();
    gnt_pct = 70; dmin = 1; dmax = 4; rdy_rand = 1'b1; flush_pct = 4;
    pops = 0;
    for (int k = 0; k < 1500; k++)
      cycle();
    vectors++;
    if (pops < 100) begin
      miscompares++;
      $display("FAIL random_progress got pops=%0d want>=100", pops);
    end
    for (int k = 0; k < 7; k++)
      cycle();
    apply_reset();
    gnt_pct = 70; dmin = 1; dmax = 4; rdy_rand = 1'b1; flush_pct = 4;
    for (int k = 0; k < 300; k++)
      cycle();
    gnt_pct = 100; rdy_rand = 1'b0; rdy_fixed = 1'b1; flush_pct = 0;
    pops = 0;
    for (int k = 0; k < 20; k++)
      cycle();
    vectors++;
    if (pops == 0) begin
      miscompares++;
      $display("FAIL drain_progress got pops=%0d want>0", pops);
    end
  endtask

`ifdef IFU_MISALIGN_CHECK_EN
  task automatic test_misalign();
    apply_reset();
    fault_pops = 0;
    flush_now = 1'b1;
    flush_tgt = 32'h102;
    cycle();
    for (int k = 0; k < 6; k++) begin
      cycle();
      vectors++;
      if (obs_req !== 1'b0 || obs_stop !== 1'b1 || pc !== 32'h102) begin
        miscompares++;
        $display("FAIL misalign_stall k=%0d got req=%b stop=%b pc=%h want req=0 stop=1 pc=00000102", k, obs_req, obs_stop, pc);
      end
    end
    vectors++;
    if (fault_pops != 1) begin
      miscompares++;
      $display("FAIL fault_count got=%0d want=1", fault_pops);
    end
    first_pop_seen = 1'b0;
    flush_now = 1'b1;
    flush_tgt = 32'h200;
    cycle();
    for (int k = 0; k < 20 && !first_pop_seen; k++)
      cycle();
    vectors++;
    if (!first_pop_seen || first_pop_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL misalign_resume got seen=%b addr=%h want seen=1 addr=00000200", first_pop_seen, first_pop_addr);
    end
  endtask
`else
  task automatic test_misalign();
    apply_reset();
    flush_now = 1'b1;
    flush_tgt = 32'h102;
    cycle();
    first_pop_seen = 1'b0;
    for (int k = 0; k < 20 && !first_pop_seen; k++)
      cycle();
    vectors++;
    if (!first_pop_seen || first_pop_addr !== 32'h102) begin
      miscompares++;
      $display("FAIL misalign_ignored got seen=%b addr=%h want seen=1 addr=00000102", first_pop_seen, first_pop_addr);
    end
  endtask
`endif

  initial begin
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_flush();
    test_full_pop();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got time=%0t want completion", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
